// File: rtl/shift_sequencer.sv
// Two-requester front end for a shared 8-bit right shifter. Requests are
// granted round-robin. Large amounts are split into passes of at most MAX_STEP.
module shift_sequencer #(
  parameter int unsigned MAX_STEP = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_A,
  input  logic       REQ_B,
  input  logic [7:0] DATA_A,
  input  logic [7:0] DATA_B,
  input  logic [7:0] AMT_A,
  input  logic [7:0] AMT_B,
  input  logic [1:0] MODE_A,
  input  logic [1:0] MODE_B,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic [7:0] SH_DATA1,
  output logic [7:0] SH_DATA2,
  output logic [1:0] SH_SETPIN,
  input  logic [7:0] SH_RESULT,
  output logic [7:0] RESULT,
  output logic       DONE,
  output logic       DONE_ID,
  output logic       ERR,
  output logic       BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  localparam logic [3:0] MAX_STEP_W = 4'(MAX_STEP);

  state_t     state, state_nx;
  logic [7:0] w;
  logic [3:0] rem;
  logic [1:0] mode_q;
  logic       id_q;
  logic       err_q;
  logic       rr_ptr;
  logic [7:0] result_q;

  logic       grant;
  logic       sel_b;
  logic [7:0] cap_data;
  logic [7:0] cap_amt;
  logic [1:0] cap_mode;
  logic       legal;
  logic [3:0] eff;
  logic [3:0] step;
  logic [3:0] rem_left;

  always_comb begin
    grant    = 1'b0;
    sel_b    = 1'b0;
    state_nx = state;
    // RESET gates the grant combinationally so a reset cycle never grants.
    if (state == ST_IDLE && !RESET && (REQ_A || REQ_B)) begin
      grant = 1'b1;
      sel_b = (REQ_A && REQ_B) ? rr_ptr : REQ_B;
    end
    cap_data = sel_b ? DATA_B : DATA_A;
    cap_amt  = sel_b ? AMT_B  : AMT_A;
    cap_mode = sel_b ? MODE_B : MODE_A;
    legal    = (cap_mode != 2'b01);
    case (cap_mode)
      2'b00:        eff = {1'b0, cap_amt[2:0]};
      2'b10, 2'b11: eff = (cap_amt >= 8'd8) ? 4'd8 : cap_amt[3:0];
      default:      eff = 4'd0;
    endcase
    step     = (rem < MAX_STEP_W) ? rem : MAX_STEP_W;
    rem_left = rem - step;

    case (state)
      ST_IDLE:  if (grant) state_nx = (legal && eff != 4'd0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (rem_left == 4'd0) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      w        <= '0;
      rem      <= '0;
      mode_q   <= '0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
      rr_ptr   <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        w      <= cap_data;
        rem    <= legal ? eff : 4'd0;
        mode_q <= cap_mode;
        id_q   <= sel_b;
        err_q  <= ~legal;
        rr_ptr <= ~sel_b;
      end else if (state == ST_SHIFT) begin
        w   <= SH_RESULT;
        rem <= rem_left;
      end
      if (state == ST_DONE) result_q <= w;
    end
  end

  // W is presented directly while DONE so the result needs no extra cycle.
  assign RESULT    = (state == ST_DONE) ? w : result_q;
  assign DONE      = (state == ST_DONE);
  assign DONE_ID   = (state == ST_DONE) & id_q;
  assign ERR       = (state == ST_DONE) & err_q;
  assign BUSY      = (state != ST_IDLE);
  assign GNT_A     = grant & ~sel_b;
  assign GNT_B     = grant & sel_b;
  assign SH_DATA1  = w;
  assign SH_DATA2  = (state == ST_SHIFT) ? {4'd0, step} : 8'd0;
  assign SH_SETPIN = (state == ST_SHIFT) ? mode_q : 2'b00;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the shared
// right shifter driving SH_RESULT.
module tb_shift_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ_A, REQ_B;
  logic [7:0] DATA_A, DATA_B, AMT_A, AMT_B;
  logic [1:0] MODE_A, MODE_B;
  logic       GNT_A, GNT_B;
  logic [7:0] SH_DATA1, SH_DATA2;
  logic [1:0] SH_SETPIN;
  logic [7:0] SH_RESULT;
  logic [7:0] RESULT;
  logic       DONE, DONE_ID, ERR, BUSY;

  int n_asserts = 0;
  int n_fail    = 0;

  shift_sequencer #(.MAX_STEP(7)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_A(REQ_A), .REQ_B(REQ_B),
    .DATA_A(DATA_A), .DATA_B(DATA_B),
    .AMT_A(AMT_A), .AMT_B(AMT_B),
    .MODE_A(MODE_A), .MODE_B(MODE_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B),
    .SH_DATA1(SH_DATA1), .SH_DATA2(SH_DATA2), .SH_SETPIN(SH_SETPIN),
    .SH_RESULT(SH_RESULT),
    .RESULT(RESULT), .DONE(DONE), .DONE_ID(DONE_ID), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [15:0] rot;
  always_comb begin
    rot       = {SH_DATA1, SH_DATA1} >> SH_DATA2;
    SH_RESULT = SH_DATA1;
    case (SH_SETPIN)
      2'b00:   SH_RESULT = rot[7:0];
      2'b10:   SH_RESULT = SH_DATA1 >> SH_DATA2;
      2'b11:   SH_RESULT = 8'($signed(SH_DATA1) >>> SH_DATA2);
      default: SH_RESULT = SH_DATA1;
    endcase
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_done(input string tag, input logic [7:0] res, input logic id, input logic err);
    chk1({tag, "_done"}, DONE, 1'b1);
    chk8({tag, "_result"}, RESULT, res);
    chk1({tag, "_id"}, DONE_ID, id);
    chk1({tag, "_err"}, ERR, err);
  endtask

  initial begin
    RESET = 1'b1;
    REQ_A = 1'b0; REQ_B = 1'b0;
    DATA_A = '0; DATA_B = '0; AMT_A = '0; AMT_B = '0;
    MODE_A = '0; MODE_B = '0;
    cyc();
    cyc();

    // c0: first cycle after reset, both requesting; A = 0x03 ROR 1, B = 0x10 SRL 4
    RESET = 1'b0;
    REQ_A = 1'b1; DATA_A = 8'h03; AMT_A = 8'd1; MODE_A = 2'b00;
    REQ_B = 1'b1; DATA_B = 8'h10; AMT_B = 8'd4; MODE_B = 2'b10;
    settle();
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_done", DONE, 1'b0);
    chk8("rst_result", RESULT, 8'h00);
    chk8("rst_sh_data1", SH_DATA1, 8'h00);
    chk8("rst_sh_data2", SH_DATA2, 8'h00);
    chk8("rst_sh_setpin", {6'd0, SH_SETPIN}, 8'h00);
    chk1("rr_c0_gnt_a", GNT_A, 1'b1);
    chk1("rr_c0_gnt_b", GNT_B, 1'b0);

    cyc(); REQ_A = 1'b0; settle();
    chk1("rr_c1_busy", BUSY, 1'b1);
    chk1("rr_c1_gnt_b", GNT_B, 1'b0);
    chk8("rr_c1_sh_data1", SH_DATA1, 8'h03);
    chk8("rr_c1_sh_data2", SH_DATA2, 8'h01);
    chk1("rr_c1_done", DONE, 1'b0);

    cyc(); settle();
    chk_done("rr_c2_a", 8'h81, 1'b0, 1'b0);
    chk1("rr_c2_gnt_b", GNT_B, 1'b0);

    cyc(); REQ_A = 1'b1; settle();
    chk1("rr_c3_gnt_b", GNT_B, 1'b1);
    chk1("rr_c3_gnt_a", GNT_A, 1'b0);
    chk1("rr_c3_done", DONE, 1'b0);
    chk8("rr_c3_result_hold", RESULT, 8'h81);

    cyc(); REQ_B = 1'b0; settle();
    chk8("rr_c4_sh_data2", SH_DATA2, 8'h04);
    chk8("rr_c4_sh_setpin", {6'd0, SH_SETPIN}, 8'h02);
    chk1("rr_c4_gnt_a", GNT_A, 1'b0);

    cyc(); settle();
    chk_done("rr_c5_b", 8'h01, 1'b1, 1'b0);

    cyc(); REQ_B = 1'b1; settle();
    chk1("rr_c6_gnt_a", GNT_A, 1'b1);
    chk1("rr_c6_gnt_b", GNT_B, 1'b0);

    cyc(); REQ_A = 1'b0; settle();
    cyc(); settle();
    chk_done("rr_c8_a", 8'h81, 1'b0, 1'b0);

    cyc(); settle();
    chk1("rr_c9_gnt_b", GNT_B, 1'b1);
    cyc(); REQ_B = 1'b0; settle();
    cyc(); settle();
    chk_done("rr_c11_b", 8'h01, 1'b1, 1'b0);

    // A: 0xB5 ROR 3
    cyc(); REQ_A = 1'b1; DATA_A = 8'hB5; AMT_A = 8'd3; MODE_A = 2'b00; settle();
    chk1("ror_gnt", GNT_A, 1'b1);
    cyc(); REQ_A = 1'b0; settle();
    chk8("ror_sh_data1", SH_DATA1, 8'hB5);
    chk8("ror_sh_data2", SH_DATA2, 8'h03);
    cyc(); settle();
    chk_done("ror", 8'hB6, 1'b0, 1'b0);

    // A: 0x90 SRA 20 -> passes of 7 then 1
    cyc(); REQ_A = 1'b1; DATA_A = 8'h90; AMT_A = 8'd20; MODE_A = 2'b11; settle();
    chk1("sra_gnt", GNT_A, 1'b1);
    cyc(); REQ_A = 1'b0; settle();
    chk8("sra_step1", SH_DATA2, 8'h07);
    chk8("sra_setpin", {6'd0, SH_SETPIN}, 8'h03);
    cyc(); settle();
    chk8("sra_step2", SH_DATA2, 8'h01);
    chk8("sra_w_mid", SH_DATA1, 8'hFF);
    chk1("sra_no_early_done", DONE, 1'b0);
    cyc(); settle();
    chk_done("sra", 8'hFF, 1'b0, 1'b0);

    // A: 0x90 SRL 20
    cyc(); REQ_A = 1'b1; MODE_A = 2'b10; settle();
    chk1("srl_gnt", GNT_A, 1'b1);
    cyc(); REQ_A = 1'b0; settle();
    cyc(); settle();
    chk8("srl_w_mid", SH_DATA1, 8'h01);
    cyc(); settle();
    chk_done("srl", 8'h00, 1'b0, 1'b0);

    // B: 0x01 ROR 9 -> effective 1
    cyc(); REQ_B = 1'b1; DATA_B = 8'h01; AMT_B = 8'd9; MODE_B = 2'b00; settle();
    chk1("ror9_gnt", GNT_B, 1'b1);
    cyc(); REQ_B = 1'b0; settle();
    chk8("ror9_sh_data2", SH_DATA2, 8'h01);
    cyc(); settle();
    chk_done("ror9", 8'h80, 1'b1, 1'b0);

    // B: ROR 8 -> effective 0, DONE right after GNT
    cyc(); REQ_B = 1'b1; AMT_B = 8'd8; settle();
    chk1("ror8_gnt", GNT_B, 1'b1);
    cyc(); REQ_B = 1'b0; settle();
    chk_done("ror8", 8'h01, 1'b1, 1'b0);
    chk8("ror8_sh_data2", SH_DATA2, 8'h00);

    // A: illegal mode 01
    cyc(); REQ_A = 1'b1; DATA_A = 8'h5A; AMT_A = 8'd3; MODE_A = 2'b01; settle();
    chk1("ill_gnt", GNT_A, 1'b1);
    chk8("ill_sh_data2_c0", SH_DATA2, 8'h00);
    cyc(); REQ_A = 1'b0; settle();
    chk_done("ill", 8'h5A, 1'b0, 1'b1);
    chk8("ill_sh_data2_c1", SH_DATA2, 8'h00);

    // A: SRA 20 aborted by reset at c2
    cyc(); REQ_A = 1'b1; DATA_A = 8'h90; AMT_A = 8'd20; MODE_A = 2'b11; settle();
    chk1("abort_done_idle", DONE, 1'b0);
    chk1("abort_err_idle", ERR, 1'b0);
    chk8("abort_result_hold", RESULT, 8'h5A);
    chk1("abort_gnt", GNT_A, 1'b1);
    cyc(); REQ_A = 1'b0; settle();
    cyc(); RESET = 1'b1;
    REQ_B = 1'b1; DATA_B = 8'h01; AMT_B = 8'd9; MODE_B = 2'b00; settle();
    chk1("abort_c2_busy", BUSY, 1'b1);
    chk1("abort_c2_gnt_b", GNT_B, 1'b0);
    cyc(); RESET = 1'b0; settle();
    chk1("abort_c3_done", DONE, 1'b0);
    chk1("abort_c3_busy", BUSY, 1'b0);
    chk8("abort_c3_result", RESULT, 8'h00);
    chk8("abort_c3_sh_data1", SH_DATA1, 8'h00);
    chk8("abort_c3_sh_data2", SH_DATA2, 8'h00);
    chk1("abort_c3_id", DONE_ID, 1'b0);
    chk1("abort_c3_gnt_b", GNT_B, 1'b1);
    cyc(); REQ_B = 1'b0; settle();
    chk1("abort_c4_done", DONE, 1'b0);
    cyc(); settle();
    chk_done("post_abort", 8'h80, 1'b1, 1'b0);

    cyc(); settle();
    chk1("final_idle", BUSY, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter MAX_STEP, default 7, giving the largest shift amount per shifter pass (legal 1..7).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports REQ_A, REQ_B  input  1  requester A/B operation request; held high until granted.
REQ-005 SHALL have ports DATA_A, DATA_B  input  8  operand to shift.
REQ-006 SHALL have ports AMT_A, AMT_B  input  8  unsigned shift amount.
REQ-007 SHALL have ports MODE_A, MODE_B  input  2  operation: 00=ROR, 10=SRL, 11=SRA, 01=illegal.
REQ-008 SHALL have ports GNT_A, GNT_B  output  1  grant; operands are captured at the edge ending the GNT cycle.
REQ-009 SHALL have ports SH_DATA1 (output 8), SH_DATA2 (output 8) and SH_SETPIN (output 2), which drive the shared right-shifter operand, amount and mode inputs.
REQ-010 SHALL have port SH_RESULT  input  8  shifter output, stable within one clock period.
REQ-011 SHALL have port RESULT  output  8  completed result; valid while DONE is high.
REQ-012 SHALL have ports DONE (output 1, one-cycle completion pulse), DONE_ID (output 1, 0=A, 1=B) and ERR (output 1, illegal mode, valid with DONE).
REQ-013 SHALL have port BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 IDLE: if REQ_A or REQ_B is high, SHALL select exactly one requester, assert that GNT for that cycle, latch DATA/AMT/MODE/ID, and set the working register W to DATA.
REQ-016 Arbitration SHALL be round-robin. A pointer selects the requester when both request. After any grant the pointer moves to the other requester. A single requester is always granted.
REQ-017 SHALL assert no GNT outside IDLE, and SHALL ignore requests while BUSY.
REQ-018 SHALL compute the effective amount at capture: ROR gives AMT mod 8; SRL and SRA give min(AMT, 8).
REQ-019 From IDLE with a grant, SHALL go to SHIFT if the effective amount is >0 and the mode is legal; otherwise it SHALL go to DONE.
REQ-020 SHIFT: SHALL drive SH_DATA1=W, SH_DATA2=step=min(rem, MAX_STEP) and SH_SETPIN=latched MODE. Each edge SHALL load W<=SH_RESULT and rem<=rem-step. When the new rem is 0, the FSM SHALL go to DONE; otherwise it SHALL stay in SHIFT.
REQ-021 Outside SHIFT, SHALL drive SH_DATA1=W, SH_DATA2=0 and SH_SETPIN=00, so the shifter output is the identity.
REQ-022 DONE: SHALL hold DONE=1, RESULT=W and DONE_ID=latched ID for exactly one cycle, then return to IDLE. A new grant is possible in the following cycle.
REQ-023 Latency SHALL be: GNT cycle, then ceil(eff/MAX_STEP) SHIFT cycles, then the DONE cycle. Effective amount 0 SHALL give DONE in the cycle after GNT.
REQ-024 Illegal mode 01: SHALL take no SHIFT cycles. DONE SHALL come in the cycle after GNT with ERR=1 and RESULT=latched DATA.
REQ-025 ERR SHALL be 0 whenever DONE is 0 or the mode is legal.
REQ-026 RESULT SHALL hold its last DONE value between completions.
REQ-027 The clock period SHALL exceed the shifter propagation delay (2 time units); SH_RESULT is sampled only on SHIFT edges.

Reset
REQ-028 While RESET is high at an edge, SHALL set: state=IDLE, W=0, rem=0, RESULT=0, DONE=0, DONE_ID=0, ERR=0, BUSY=0, GNT_A=GNT_B=0, round-robin pointer=A.
REQ-029 Reset during SHIFT or DONE SHALL abort the transaction with no DONE pulse; requests SHALL be arbitrated again from IDLE after RESET falls.
REQ-030 SH_DATA1 and SH_DATA2 SHALL be 0 and SH_SETPIN 00 in the cycle after reset.

Verification
REQ-031 A: DATA=0xB5, AMT=3, MODE=00 -> GNT_A at c0, SHIFT c1, DONE at c2 with RESULT=0xB6, DONE_ID=0, ERR=0.
REQ-032 A: DATA=0x90, AMT=20, MODE=11 -> steps 7 then 1, DONE at c3 with RESULT=0xFF. Same with MODE=10 -> RESULT=0x00.
REQ-033 B: DATA=0x01, AMT=9, MODE=00 -> effective 1, DONE at c2 with RESULT=0x80, DONE_ID=1. With AMT=8 -> DONE at c1 with RESULT=0x01.
REQ-034 First cycle after reset, REQ_A and REQ_B both high (A: ROR by 1) -> GNT_A c0, DONE c2 with ID 0, GNT_B c3; grants SHALL alternate under sustained contention.
REQ-035 A with MODE=01, DATA=0x5A -> DONE at c1 with ERR=1, RESULT=0x5A, and SH_DATA2 held at 0 throughout.
REQ-036 SRA by 20 with RESET pulsed at c2 -> no DONE; all outputs at reset values from c3; a new request is granted once RESET is low.
